// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-port memory between the fetch (I) and load/store (D) ports.
// Optional ARB_ROUND_ROBIN_EN: alternate grants on contention instead of fixed D-over-I priority.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_ack,
  output logic [DATA_W-1:0]     if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_be,
  output logic                  d_ack,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_be,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  core_stall,
  output logic [1:0]            dbg_state
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

  if (MEM_LAT < 1) begin : g_lat_check
    $error("mem_port_arbiter: MEM_LAT must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state;
  logic                owner_d;
  logic                we_q;
  logic                first_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [BE_W-1:0]     be_q;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   rdata_q;
  logic                if_ack_q;
  logic                d_ack_q;
  logic                grant_d;

  // Handshake: a port raises req and holds its request fields stable until it sees a
  // one-cycle ack; the ack cycle is the only cycle in which its rdata is meaningful.
`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;

  always_comb grant_d = d_req & (~if_req | ~last_d);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_d <= 1'b0;
    end else if (state == IDLE && (if_req | d_req)) begin
      last_d <= grant_d;
    end
  end
`else
  always_comb grant_d = d_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      owner_d  <= 1'b0;
      we_q     <= 1'b0;
      first_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      cnt      <= '0;
      rdata_q  <= '0;
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
    end else begin
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      first_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req | d_req) begin
            owner_d <= grant_d;
            we_q    <= grant_d & d_we;
            addr_q  <= grant_d ? d_addr : if_addr;
            wdata_q <= grant_d ? d_wdata : '0;
            be_q    <= grant_d ? d_be : '0;
            cnt     <= CNT_W'(MEM_LAT);
            first_q <= 1'b1;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          cnt <= cnt - 1'b1;
          // Last access cycle: memory data is valid now, stores return zero.
          if (cnt == CNT_W'(1)) begin
            rdata_q  <= we_q ? '0 : mem_rdata;
            if_ack_q <= ~owner_d;
            d_ack_q  <= owner_d;
            state    <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic in_access;
  assign in_access = (state == ACCESS);

  assign mem_req    = first_q;
  assign mem_we     = in_access & we_q;
  assign mem_addr   = in_access ? addr_q : '0;
  assign mem_wdata  = in_access ? wdata_q : '0;
  assign mem_be     = in_access ? be_q : '0;
  assign if_ack     = if_ack_q;
  assign d_ack      = d_ack_q;
  assign if_rdata   = rdata_q;
  assign d_rdata    = rdata_q;
  assign core_stall = (if_req & ~if_ack_q) | (d_req & ~d_ack_q);
  assign dbg_state  = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-schedule model checked every cycle plus directed vectors.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int MEM_LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [BW-1:0] d_be = '0;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic [DW-1:0] mem_rdata;
  logic          core_stall;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata),
    .core_stall(core_stall), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_release_idle", 32'(dbg_state), 32'd0);
  endtask

  // ---------------- memory contents ----------------
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEAD_BEEF;
    return {a[15:0] ^ 16'h1234, a[15:0]};
  endfunction

  always_comb mem_rdata = mem_fn(mem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: one transaction scheduled per accept edge ----------------
  int            cyc = 0;
  bit            busy = 1'b0;
  int            t0 = 0;
  bit            own_d, m_we, m_gd;
  bit            last_d = 1'b0;
  logic [31:0]   m_addr, m_wdata;
  logic [BW-1:0] m_be;
  logic [DW-1:0] exp_q[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy   = 1'b0;
      last_d = 1'b0;
      exp_q.delete();
    end else begin
      cyc++;
      if (busy && cyc == t0 + MEM_LAT) exp_q.push_back(m_we ? 32'd0 : mem_fn(m_addr));
      if (busy && cyc >= t0 + MEM_LAT + 2) busy = 1'b0;
      if (!busy && (if_req || d_req)) begin
`ifdef ARB_ROUND_ROBIN_EN
        m_gd = d_req && (!if_req || !last_d);
`else
        m_gd = d_req;
`endif
        last_d  = m_gd;
        busy    = 1'b1;
        t0      = cyc;
        own_d   = m_gd;
        m_we    = m_gd && d_we;
        m_addr  = m_gd ? d_addr : if_addr;
        m_wdata = d_wdata;
        m_be    = m_gd ? d_be : '0;
      end
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  bit          e_acc, e_ack;
  logic [31:0] e_data;

  always begin
    @(posedge clk);
    #3;
    if (!rst) begin
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_mem_be", 32'(mem_be), 32'd0);
      chk("rst_if_ack", 32'(if_ack), 32'd0);
      chk("rst_d_ack", 32'(d_ack), 32'd0);
      chk("rst_rdata", if_rdata | d_rdata, 32'd0);
      chk("rst_stall", 32'(core_stall), 32'(if_req | d_req));
    end else begin
      e_acc = busy && cyc >= t0 && cyc < t0 + MEM_LAT;
      e_ack = busy && cyc == t0 + MEM_LAT;
      chk("mem_req", 32'(mem_req), 32'(busy && cyc == t0));
      chk("if_ack", 32'(if_ack), 32'(e_ack && !own_d));
      chk("d_ack", 32'(d_ack), 32'(e_ack && own_d));
      chk("core_stall", 32'(core_stall),
          32'((if_req && !(e_ack && !own_d)) || (d_req && !(e_ack && own_d))));
      if (e_acc) begin
        chk("mem_we", 32'(mem_we), 32'(m_we));
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_be", 32'(mem_be), 32'(m_be));
        if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
      end
      if (e_ack) begin
        if (exp_q.size() == 0) begin
          chk("exp_q_empty", 32'd1, 32'd0);
        end else begin
          e_data = exp_q.pop_front();
          if (own_d) chk("d_rdata", d_rdata, e_data);
          else       chk("if_rdata", if_rdata, e_data);
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_ack(input bit want_d, output int lat, output logic [31:0] data,
                          output int nreq, output int nwe);
    lat = 0; nreq = 0; nwe = 0; data = '0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #3;
      lat++;
      if (mem_req) nreq++;
      if (mem_we && mem_wdata == 32'h1234_5678 && mem_be == 4'b0011 && mem_addr == 32'h40) nwe++;
      if (want_d ? d_ack : if_ack) begin
        data = want_d ? d_rdata : if_rdata;
        return;
      end
    end
    chk("ack_timeout", 32'd0, 32'd1);
    lat = -1;
  endtask

  task automatic wait_any(output bit who_d);
    who_d = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #3;
      if (d_ack || if_ack) begin
        who_d = d_ack;
        return;
      end
    end
    chk("any_ack_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- directed vectors ----------------
  int          lat, nreq, nwe;
  logic [31:0] data;
  logic [3:0]  grants;
  bit          who;

  initial begin
    // 1: reset state
    repeat (3) @(negedge clk);
    chk("rst_stall_noreq", 32'(core_stall), 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_release_idle", 32'(dbg_state), 32'd0);

    // 2: single fetch
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h10;
    wait_ack(1'b0, lat, data, nreq, nwe);
    chk("t2_if_lat", 32'(lat), 32'd3);
    chk("t2_if_rdata", data, 32'hDEAD_BEEF);
    chk("t2_mem_req_cycles", 32'(nreq), 32'd1);
    @(negedge clk);
    if_req = 1'b0;

    // 3: contention, D wins, I follows 4 cycles later
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    if_req = 1'b1; if_addr = 32'h24;
    wait_ack(1'b1, lat, data, nreq, nwe);
    chk("t3_d_lat", 32'(lat), 32'd3);
    chk("t3_d_rdata", data, 32'h1034_0200);
    @(negedge clk);
    d_req = 1'b0;
    wait_ack(1'b0, lat, data, nreq, nwe);
    chk("t3_if_after_d", 32'(lat), 32'd4);
    chk("t3_if_rdata", data, 32'h1210_0024);
    @(negedge clk);
    if_req = 1'b0;

    // 4: store
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_be = 4'b0011; d_wdata = 32'h1234_5678;
    wait_ack(1'b1, lat, data, nreq, nwe);
    chk("t4_st_lat", 32'(lat), 32'd3);
    chk("t4_st_wcycles", 32'(nwe), 32'd2);
    chk("t4_st_rdata", data, 32'd0);
    @(negedge clk);
    d_req = 1'b0; d_we = 1'b0; d_be = '0; d_wdata = '0;

    // 6: reset during the second access cycle, request held, reissues
    @(negedge clk);
    d_req = 1'b1; d_addr = 32'h80;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_rst_mem_req", 32'(mem_req), 32'd0);
    chk("t6_rst_d_ack", 32'(d_ack), 32'd0);
    chk("t6_rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    wait_ack(1'b1, lat, data, nreq, nwe);
    chk("t6_reissue_lat", 32'(lat), 32'd3);
    chk("t6_reissue_rdata", data, 32'h12B4_0080);
    @(negedge clk);
    d_req = 1'b0;

    // 5: sustained contention from reset
    do_reset();
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h24;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    for (int k = 0; k < 4; k++) begin
      wait_any(who);
      grants[3-k] = who;
    end
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    chk("t5_grant_seq", 32'(grants), 32'b1010);
`else
    chk("t5_grant_seq", 32'(grants), 32'b1111);
`endif

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
